// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU round-robin scheduler.
//   - ALU op encodings (3 bits), operand and result widths.
//   - Scheduler FSM state encoding.
//   - A small debug struct that bundles the FSM-visible state.
package alu_pkg;

  localparam int OP_W   = 3;
  localparam int OPND_W = 8;
  localparam int RES_W  = 16;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_MUL = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Snapshot of the scheduler's control state, kept together so a checker
  // can bind to one signal.
  typedef struct packed {
    state_e     state;
    logic [7:0] gnt_id;
    logic [7:0] rr_ptr;
    logic       end_q;
  } sched_dbg_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req_i    : request vector, one bit per requester
//   ptr_i    : index of the most recently granted requester
//   gnt_o    : one-hot grant (all zero when no request)
//   gnt_id_o : encoded index of the granted requester
//   any_o    : high when some request is present
// The search starts at ptr_i+1 and wraps, so the last winner has lowest
// priority on the next round.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               any_o
);

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[idx]) begin
        any_o       = 1'b1;
        gnt_id_o    = ID_W'(idx);
        gnt_o[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one multi-cycle ALU between NUM_REQ requesters.
//   clk, resetn           : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester request level / one-cycle accept
//   req_op/req_x/req_y    : packed per-requester job fields
//   rsp_valid/rsp_data    : one-hot result strobe and 16-bit result
//   rsp_err               : qualifies rsp_valid, job aborted by watchdog
//   busy                  : scheduler is not idle
//   alu_x/alu_y/alu_op    : operands to the ALU, stable LAUNCH..RESP
//   alu_begin/alu_end     : ALU start pulse / completion level
//   alu_out               : ALU result
//
// Handshake: a requester holds req_valid until it sees req_ready high in a
// cycle; that cycle's rising edge is the accept and latches the operands.
// req_ready is a decode of the IDLE state plus the arbiter so that an
// accept can occur in the very first IDLE cycle after a response.
// rsp_valid is a single-cycle strobe with no back-pressure.
//
// Flow: IDLE (grant) -> LAUNCH (alu_begin high) -> WAIT (edge detect
// on alu_end, watchdog) -> RESP (rsp_valid high) -> IDLE.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OP_W*NUM_REQ-1:0]   req_op,
  input  logic [OPND_W*NUM_REQ-1:0] req_x,
  input  logic [OPND_W*NUM_REQ-1:0] req_y,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [OPND_W-1:0]         alu_x,
  output logic [OPND_W-1:0]         alu_y,
  output logic [OP_W-1:0]           alu_op,
  output logic                      alu_begin,
  input  logic [RES_W-1:0]          alu_out,
  input  logic                      alu_end
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e               state_q;
  logic [ID_W-1:0]      gnt_id_q;
  logic [ID_W-1:0]      rr_ptr_q;
  logic                 end_q;
  logic [WD_W-1:0]      wd_q;
  logic [OPND_W-1:0]    alu_x_q;
  logic [OPND_W-1:0]    alu_y_q;
  logic [OP_W-1:0]      alu_op_q;
  logic                 alu_begin_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [RES_W-1:0]     rsp_data_q;
  logic                 rsp_err_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [ID_W-1:0]      arb_id;
  logic                 arb_any;
  logic                 end_rise;
  logic [NUM_REQ-1:0]   gnt_onehot;
  sched_dbg_t           dbg;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (arb_gnt),
    .gnt_id_o (arb_id),
    .any_o    (arb_any)
  );

  assign end_rise   = alu_end & ~end_q;
  assign gnt_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id_q;

  // resetn gates the accept so a requester holding req_valid through
  // reset never sees a phantom accept.
  assign req_ready = (resetn && state_q == ST_IDLE) ? arb_gnt : '0;
  assign busy      = (state_q != ST_IDLE);
  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_op    = alu_op_q;
  assign alu_begin = alu_begin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    dbg        = '0;
    dbg.state  = state_q;
    dbg.gnt_id = 8'(gnt_id_q);
    dbg.rr_ptr = 8'(rr_ptr_q);
    dbg.end_q  = end_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      gnt_id_q    <= '0;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      end_q       <= 1'b0;
      wd_q        <= '0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      alu_op_q    <= '0;
      alu_begin_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      end_q       <= alu_end;
      alu_begin_q <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            alu_op_q    <= req_op[OP_W*int'(arb_id) +: OP_W];
            alu_x_q     <= req_x[OPND_W*int'(arb_id) +: OPND_W];
            alu_y_q     <= req_y[OPND_W*int'(arb_id) +: OPND_W];
            gnt_id_q    <= arb_id;
            rr_ptr_q    <= arb_id;
            // Raised here so it is visible for exactly the LAUNCH cycle.
            alu_begin_q <= 1'b1;
            state_q     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wd_q    <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion is tested first so it wins over a same-cycle timeout.
          if (end_rise) begin
            rsp_data_q  <= alu_out;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= gnt_onehot;
            state_q     <= ST_RESP;
          end else if (wd_q == WD_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= gnt_onehot;
            state_q     <= ST_RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_RESP: begin
          rsp_err_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;
  localparam int EW      = ID_W + 1 + 16;

  logic                 clk;
  logic                 resetn;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [3*NUM_REQ-1:0] req_op;
  logic [8*NUM_REQ-1:0] req_x;
  logic [8*NUM_REQ-1:0] req_y;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [15:0]          rsp_data;
  logic                 rsp_err;
  logic                 busy;
  logic [7:0]           alu_x;
  logic [7:0]           alu_y;
  logic [2:0]           alu_op;
  logic                 alu_begin;
  logic [15:0]          alu_out;
  logic                 alu_end;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_end_cyc = 0;
  int rsp_count = 0;

  logic [EW-1:0] exp_q[$];

  alu_rr_scheduler #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_op    (alu_op),
    .alu_begin (alu_begin),
    .alu_out   (alu_out),
    .alu_end   (alu_end)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- behavioural ALU ----------------
  // mode 0: END rises alu_delay cycles after BEGIN; mode 1: never ends;
  // mode 2: END/OUT driven directly by the test sequence.
  int          alu_mode  = 0;
  int          alu_delay = 1;
  int          alu_cnt   = 0;
  bit          alu_run   = 0;
  logic [15:0] alu_res;

  function automatic logic [15:0] alu_calc(input logic [2:0] op,
                                           input logic [7:0] x,
                                           input logic [7:0] y);
    logic signed [15:0] sx, sy;
    sx = 16'(signed'(x));
    sy = 16'(signed'(y));
    case (op)
      OP_ADD:  return sx + sy;
      OP_SUB:  return sx - sy;
      OP_MUL:  return sx * sy;
      default: return 16'h0000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!resetn) begin
      alu_run = 0;
    end else if (alu_mode != 2) begin
      if (alu_begin) begin
        alu_end = 1'b0;
        alu_res = alu_calc(alu_op, alu_x, alu_y);
        alu_cnt = alu_delay;
        alu_run = (alu_mode == 0);
      end else if (alu_run) begin
        alu_cnt--;
        if (alu_cnt == 0) begin
          alu_out      = alu_res;
          alu_end      = 1'b1;
          alu_run      = 0;
          last_end_cyc = cyc;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (resetn && rsp_valid != '0) begin
      rsp_count++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'h0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("rsp_valid_id", 32'(rsp_valid), 32'(1) << e[EW-1:17]);
        check("rsp_err", 32'(rsp_err), 32'(e[16]));
        check("rsp_data", 32'(rsp_data), 32'(e[15:0]));
        if (!e[16]) check("rsp_latency", cyc, last_end_cyc + 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input logic [2:0] op,
                         input logic [7:0] x, input logic [7:0] y);
    req_op[3*id +: 3] = op;
    req_x[8*id +: 8]  = x;
    req_y[8*id +: 8]  = y;
  endtask

  // Waits for the accept of requester id, queues the expected response,
  // then checks the ALU launch one cycle later. Returns the accept cycle.
  task automatic accept(input int id, input logic [2:0] op,
                        input logic [7:0] x, input logic [7:0] y,
                        input logic err, input logic [15:0] data,
                        output int t);
    bit seen;
    seen = 0;
    t = cyc;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (req_ready != '0) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      check("accept_timeout", 32'(req_ready), 32'(1) << id);
      return;
    end
    t = cyc;
    check("req_ready", 32'(req_ready), 32'(1) << id);
    exp_q.push_back({ID_W'(id), err, data});
    @(negedge clk);
    check("alu_begin", 32'(alu_begin), 32'h1);
    check("alu_operands", {13'h0, alu_op, alu_x, alu_y}, {13'h0, op, x, y});
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) check("idle_timeout", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {19'h0, req_ready, rsp_valid, rsp_err, busy, alu_begin, alu_op},
          32'h0);
    check({tag, "_data"}, {rsp_data, alu_x, alu_y}, 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          id;
    logic [2:0]  op;
    logic [7:0]  x;
    logic [7:0]  y;
    int          delay;
    bit          keep;   // hold req_valid for the next entry
    bit          gap;    // accept must land 2 cycles after previous END
    logic [15:0] exp;
  } vec_t;

  vec_t vt[6];

  // ---------------- main sequence ----------------
  initial begin
    int t, b, saved;
    bit seen;

    vt[0] = '{0, OP_MUL, 8'hB9, 8'h85, 9, 0, 0, 16'h221D};
    vt[1] = '{2, OP_ADD, 8'h7F, 8'h01, 1, 1, 0, 16'h0080};
    vt[2] = '{2, OP_SUB, 8'h80, 8'h01, 3, 1, 1, 16'hFF7F};
    vt[3] = '{2, OP_MUL, 8'hFF, 8'h02, 2, 1, 1, 16'hFFFE};
    vt[4] = '{2, OP_MUL, 8'h7F, 8'h7F, 5, 1, 1, 16'h3F01};
    vt[5] = '{2, OP_ADD, 8'h80, 8'h80, 4, 0, 1, 16'hFF00};

    resetn    = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_x     = '0;
    req_y     = '0;
    alu_out   = '0;
    alu_end   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Rotation: all four requesters held, expect 0,1,2,3,0.
    alu_mode  = 0;
    alu_delay = 2;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, OP_MUL, 8'(i + 1), 8'h03);
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      accept(k % 4, OP_MUL, 8'(k % 4 + 1), 8'h03, 1'b0, 16'(3 * (k % 4 + 1)), t);
    end
    req_valid = '0;
    wait_idle();

    // Table: single job from requester 0, then requester 2 streaming.
    for (int i = 0; i < 6; i++) begin
      set_req(vt[i].id, vt[i].op, vt[i].x, vt[i].y);
      req_valid[vt[i].id] = 1'b1;
      alu_delay = vt[i].delay;
      accept(vt[i].id, vt[i].op, vt[i].x, vt[i].y, 1'b0, vt[i].exp, t);
      if (vt[i].gap) check("accept_gap", t - last_end_cyc, 2);
      if (!vt[i].keep) req_valid[vt[i].id] = 1'b0;
    end
    wait_idle();

    // Timeout: END never rises.
    alu_mode = 1;
    set_req(1, OP_ADD, 8'h11, 8'h22);
    req_valid[1] = 1'b1;
    accept(1, OP_ADD, 8'h11, 8'h22, 1'b1, 16'h0000, b);
    req_valid[1] = 1'b0;
    b = cyc;
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (rsp_valid != '0) begin
        seen = 1;
        break;
      end
    end
    check("timeout_seen", 32'(seen), 32'h1);
    check("timeout_latency", cyc - b, TIMEOUT + 1);
    wait_idle();

    // Late END after the timeout must be ignored.
    alu_mode = 2;
    @(negedge clk);
    alu_out = 16'hBEEF;
    alu_end = 1'b1;
    saved = rsp_count;
    repeat (8) @(negedge clk);
    check("late_end_no_rsp", rsp_count, saved);
    check("late_end_idle", 32'(busy), 32'h0);

    // END still high at launch: needs a fresh rising edge.
    alu_out = 16'h0019;
    set_req(3, OP_MUL, 8'h05, 8'h05);
    req_valid[3] = 1'b1;
    accept(3, OP_MUL, 8'h05, 8'h05, 1'b0, 16'h0019, t);
    req_valid[3] = 1'b0;
    repeat (10) @(negedge clk);
    check("stuck_end_no_rsp", rsp_count, saved);
    check("stuck_end_busy", 32'(busy), 32'h1);
    alu_end = 1'b0;
    repeat (2) @(negedge clk);
    alu_end = 1'b1;
    last_end_cyc = cyc;
    wait_idle();
    check("stuck_end_rsp", rsp_count, saved + 1);

    // Reset mid-WAIT: job dropped, next grant goes to requester 0.
    alu_mode = 1;
    set_req(1, OP_SUB, 8'h09, 8'h04);
    req_valid[1] = 1'b1;
    accept(1, OP_SUB, 8'h09, 8'h04, 1'b1, 16'h0000, t);
    req_valid[1] = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midwait_reset");
    exp_q.delete();
    saved = rsp_count;
    alu_mode = 0;
    alu_delay = 3;
    alu_end = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, OP_MUL, 8'(i + 1), 8'h03);
    req_valid = '1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midwait_hold");
    check("midwait_no_rsp", rsp_count, saved);
    resetn = 1'b1;
    accept(0, OP_MUL, 8'h01, 8'h03, 1'b0, 16'h0003, t);
    req_valid = '0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
